// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the skewed read-address generator.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int DEF_ADDR_WIDTH = 8;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  function automatic int accum_rows(input int accum_size, input int sys_col);
    return accum_size / sys_col;
  endfunction

  function automatic int cnt_width(input int accum_row, input int sys_row);
    return $clog2(accum_row + sys_row) + 1;
  endfunction

endpackage

// File: rtl/mem_rd_skew_ctrl_if.sv
// Control/bus bundle between the layer controller (master) and the read generator (slave).
interface mem_rd_skew_ctrl_if #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) ();

  logic                          start;
  logic                          skew_en;
  logic [DATA_WIDTH-1:0]         num_row;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic                          stall;
  logic                          busy;
  logic                          done;
  logic [SYS_ROW-1:0]            rd_en;
  logic [SYS_ROW*ADDR_WIDTH-1:0] rd_addr;
  logic [SYS_ROW-1:0]            data_vld;

  modport master (
    output start, skew_en, num_row, base_addr, stall,
    input  busy, done, rd_en, rd_addr, data_vld
  );

  modport slave (
    input  start, skew_en, num_row, base_addr, stall,
    output busy, done, rd_en, rd_addr, data_vld
  );

endinterface

// File: rtl/mem_vld_delay.sv
// Fixed-depth shift pipeline turning issued read enables into data-valid strobes.
module mem_vld_delay #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pending
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < DEPTH; j++) pipe[j] <= '0;
    end else begin
      pipe[0] <= din;
      for (int j = 1; j < DEPTH; j++) pipe[j] <= pipe[j-1];
    end
  end

  assign dout = pipe[DEPTH-1];

  // Stages that still need more than one shift to reach dout.
  always_comb begin
    pending = 1'b0;
    for (int j = 0; j < DEPTH - 2; j++) pending = pending | (|pipe[j]);
  end

endmodule

// File: rtl/mem_rd_skew_ctrl.sv
// Per-lane read enable/address generator for the accumulator buffer, with skewed or
// aligned issue, stall, and a latency-matched data-valid output.
module mem_rd_skew_ctrl
  import mem_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 4096,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input logic              clk,
  input logic              rstn,
  mem_rd_skew_ctrl_if.slave bus
);

  localparam int ACCUM_ROW = accum_rows(ACCUM_SIZE, SYS_COL);
  localparam int CW        = cnt_width(ACCUM_ROW, SYS_ROW);
  localparam int AW        = ADDR_WIDTH;

  if (SYS_ROW < 2) begin : g_chk_row
    $error("mem_rd_skew_ctrl: SYS_ROW must be >= 2");
  end
  if (RD_LATENCY < 1) begin : g_chk_lat
    $error("mem_rd_skew_ctrl: RD_LATENCY must be >= 1");
  end
  if (ACCUM_ROW > 2**ADDR_WIDTH) begin : g_chk_addr
    $error("mem_rd_skew_ctrl: ACCUM_ROW does not fit in ADDR_WIDTH");
  end

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next, n_q, n_next, l_q, l_next, n_clamp;
  logic                skew_q, skew_next;
  logic [SYS_ROW-1:0]  slot_q, slot_next, rd_en_q, rd_en_next, vld;
  logic [SYS_ROW*AW-1:0] addr_q, addr_next;
  logic                busy_q, done_q, pending;

  // Lane 0 fires for the first n slots; other lanes either trail their neighbour or copy lane 0.
  function automatic logic [SYS_ROW-1:0] next_slot(input logic [CW-1:0] k, input logic [CW-1:0] n,
                                                   input logic sk, input logic [SYS_ROW-1:0] prev);
    logic [SYS_ROW-1:0] s;
    s[0] = (k < n);
    for (int i = 1; i < SYS_ROW; i++) s[i] = sk ? prev[i-1] : s[0];
    return s;
  endfunction

  always_comb begin
    if (32'(bus.num_row) > 32'(ACCUM_ROW)) n_clamp = CW'(ACCUM_ROW);
    else                                   n_clamp = CW'(bus.num_row);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    n_next     = n_q;
    l_next     = l_q;
    skew_next  = skew_q;
    slot_next  = slot_q;
    rd_en_next = '0;
    for (int i = 0; i < SYS_ROW; i++)
      addr_next[i*AW +: AW] = rd_en_q[i] ? addr_q[i*AW +: AW] + AW'(1) : addr_q[i*AW +: AW];
    case (state)
      IDLE: begin
        if (bus.start) begin
          n_next    = n_clamp;
          skew_next = bus.skew_en;
          l_next    = bus.skew_en ? n_clamp + CW'(SYS_ROW - 1) : n_clamp;
          cnt_next  = '0;
          slot_next = '0;
          if (n_clamp == '0) begin
            state_next = FIN;
          end else begin
            state_next = RUN;
            addr_next  = {SYS_ROW{bus.base_addr}};
            if (!bus.stall) begin
              slot_next  = next_slot('0, n_clamp, bus.skew_en, '0);
              rd_en_next = slot_next;
              cnt_next   = CW'(1);
            end
          end
        end
      end
      RUN: begin
        if (cnt == l_q) begin
          state_next = (RD_LATENCY == 1) ? FIN : DRAIN;
          addr_next  = '1;
        end else if (!bus.stall) begin
          slot_next  = next_slot(cnt, n_q, skew_q, slot_q);
          rd_en_next = slot_next;
          cnt_next   = cnt + CW'(1);
        end
      end
      DRAIN: begin
        // Leave once only the output stage can still hold a valid strobe.
        if (!pending) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      n_q     <= '0;
      l_q     <= '0;
      skew_q  <= 1'b0;
      slot_q  <= '0;
      rd_en_q <= '0;
      addr_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      n_q     <= n_next;
      l_q     <= l_next;
      skew_q  <= skew_next;
      slot_q  <= slot_next;
      rd_en_q <= rd_en_next;
      addr_q  <= addr_next;
      busy_q  <= (state_next != IDLE);
      done_q  <= (state_next == FIN);
    end
  end

  mem_vld_delay #(.WIDTH(SYS_ROW), .DEPTH(RD_LATENCY)) u_vld_delay (
    .clk     (clk),
    .clr     (!rstn),
    .din     (rd_en_q),
    .dout    (vld),
    .pending (pending)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = addr_q;
  assign bus.data_vld = vld;

endmodule

// File: tb/tb_mem_rd_skew_ctrl.sv
// Randomized self-checking bench for mem_rd_skew_ctrl against a slot/latency schedule model.
module tb_mem_rd_skew_ctrl;
  import mem_pkg::*;

  localparam int SYS_ROW    = 4;
  localparam int SYS_COL    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ACCUM_SIZE = 64;
  localparam int ADDR_WIDTH = 8;
  localparam int RD_LATENCY = 2;
  localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL;
  localparam int HN         = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  mem_rd_skew_ctrl_if #(.SYS_ROW(SYS_ROW), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  mem_rd_skew_ctrl #(
    .SYS_ROW(SYS_ROW), .SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH),
    .ACCUM_SIZE(ACCUM_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;
  int g_cyc     = 0;

  // Reference schedule: slot k puts lane i at row k-i (skewed) or k (aligned).
  bit                 m_active   = 1'b0;
  bit                 m_skew     = 1'b0;
  bit                 m_idle_one = 1'b1;
  int                 m_n, m_l, m_k;
  int                 m_done_at  = -1;
  addr_t              m_base;
  logic [SYS_ROW-1:0] hist [HN];
  logic [SYS_ROW-1:0] exp_rd, exp_vld;
  logic               exp_busy, exp_done;
  addr_t              exp_addr [SYS_ROW];

  int    rd_cnt0;
  addr_t last_addr0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, g_cyc);
    end
  endtask

  task automatic emitSlot(input int nxt, output logic [SYS_ROW-1:0] rd);
    int idx;
    for (int i = 0; i < SYS_ROW; i++) begin
      idx         = m_skew ? m_k - i : m_k;
      rd[i]       = (idx >= 0) && (idx < m_n);
      exp_addr[i] = addr_t'(int'(m_base) + idx);
    end
    if (m_k == m_l - 1) m_done_at = nxt + RD_LATENCY;
    m_k++;
  endtask

  task automatic modelEdge();
    int c, nxt, nr;
    bit was;
    logic [SYS_ROW-1:0] new_rd;
    c = g_cyc;
    nxt = c + 1;
    new_rd = '0;
    if (!rstn) begin
      m_active   = 1'b0;
      m_done_at  = -1;
      m_idle_one = 1'b1;
      hist[c % HN] = '0;
      hist[(c + HN - 1) % HN] = '0;
    end else begin
      was = m_active;
      if (m_active && m_done_at == c) begin
        m_active = 1'b0;
        if (m_n > 0) m_idle_one = 1'b1;
      end
      if (!was && bus.start) begin
        nr         = int'(bus.num_row);
        m_n        = (nr > ACCUM_ROW) ? ACCUM_ROW : nr;
        m_skew     = bus.skew_en;
        m_base     = bus.base_addr;
        m_l        = m_skew ? m_n + SYS_ROW - 1 : m_n;
        m_k        = 0;
        m_active   = 1'b1;
        m_idle_one = 1'b0;
        if (m_n == 0) m_done_at = nxt;
        else begin
          m_done_at = -1;
          if (!bus.stall) emitSlot(nxt, new_rd);
        end
      end else if (m_active && m_k < m_l) begin
        if (!bus.stall) emitSlot(nxt, new_rd);
      end
    end
    hist[nxt % HN] = new_rd;
    exp_rd   = new_rd;
    exp_vld  = (nxt >= RD_LATENCY) ? hist[(nxt - RD_LATENCY) % HN] : '0;
    exp_done = m_active && (m_done_at == nxt);
    exp_busy = m_active;
  endtask

  task automatic checkAll();
    checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
    checkOutput("done", 32'(bus.done), 32'(exp_done));
    checkOutput("rd_en", 32'(bus.rd_en), 32'(exp_rd));
    checkOutput("data_vld", 32'(bus.data_vld), 32'(exp_vld));
    for (int i = 0; i < SYS_ROW; i++)
      if (exp_rd[i])
        checkOutput($sformatf("rd_addr%0d", i), 32'(bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), 32'(exp_addr[i]));
    if (!exp_busy && m_idle_one)
      checkOutput("rd_addr_idle", 32'(bus.rd_addr), 32'({SYS_ROW*ADDR_WIDTH{1'b1}}));
    if (bus.rd_en[0] === 1'b1) begin
      rd_cnt0++;
      last_addr0 = bus.rd_addr[ADDR_WIDTH-1:0];
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sk, input int nr, input int base,
                               input bit stl, input bit rn);
    bus.start     = st;
    bus.skew_en   = sk;
    bus.num_row   = DATA_WIDTH'(nr);
    bus.base_addr = ADDR_WIDTH'(base);
    bus.stall     = stl;
    rstn          = rn;
    @(posedge clk);
    modelEdge();
    g_cyc++;
    @(negedge clk);
    checkAll();
  endtask

  // One job: start in job cycle 0, optional forced stall cycle, random stall rate,
  // start spam while busy, and an optional reset cycle; reports the observed done cycle.
  task automatic runJob(input bit sk, input int nr, input int base, input int stall_cyc,
                        input int stall_pct, input bit spam, input int rst_at, output int done_cyc);
    int jc;
    bit stl;
    done_cyc = -1;
    rd_cnt0  = 0;
    stl = (stall_cyc == 0) || (stall_pct > 0 && $urandom_range(99) < stall_pct);
    applyStimulus(1'b1, sk, nr, base, stl, 1'b1);
    if (bus.done === 1'b1) done_cyc = 1;
    for (jc = 1; jc < 200; jc++) begin
      if (!m_active) break;
      stl = (jc == stall_cyc) || (stall_pct > 0 && $urandom_range(99) < stall_pct);
      applyStimulus(spam && ($urandom_range(1) == 1), $urandom_range(1) == 1,
                    $urandom_range(24), $urandom_range(255), stl, jc != rst_at);
      if (bus.done === 1'b1) done_cyc = jc + 1;
    end
    if (m_active) checkOutput("job_end", 32'(m_active), 32'(0));
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    for (int i = 0; i < HN; i++) hist[i] = '0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    runJob(1'b1, 3, 'h10, -1, 0, 1'b0, -1, d);
    checkOutput("skew_done_cyc", 32'(d), 32'(8));
    runJob(1'b0, 3, 'h10, -1, 0, 1'b0, -1, d);
    checkOutput("align_done_cyc", 32'(d), 32'(5));
    runJob(1'b1, 3, 'h10, 2, 0, 1'b0, -1, d);
    checkOutput("stall_done_cyc", 32'(d), 32'(9));
    runJob(1'b1, 20, 'h40, -1, 0, 1'b0, -1, d);
    checkOutput("clamp_reads", 32'(rd_cnt0), 32'(16));
    checkOutput("clamp_last_addr", 32'(last_addr0), 32'('h4F));
    runJob(1'b0, 4, 'hFE, -1, 0, 1'b0, -1, d);
    checkOutput("wrap_last_addr", 32'(last_addr0), 32'('h01));
    runJob(1'b0, 0, 'h22, -1, 0, 1'b0, -1, d);
    checkOutput("zero_done_cyc", 32'(d), 32'(1));
    checkOutput("zero_reads", 32'(rd_cnt0), 32'(0));
    runJob(1'b1, 5, 'h80, -1, 0, 1'b0, 3, d);
    checkOutput("rst_no_done", d, -1);
    runJob(1'b0, 5, 'h30, -1, 0, 1'b1, -1, d);
    checkOutput("spam_done_cyc", 32'(d), 32'(7));

    for (int j = 0; j < 60; j++) begin
      runJob($urandom_range(1) == 1, $urandom_range(24), $urandom_range(255), -1,
             ($urandom_range(1) == 1) ? 25 : 0, $urandom_range(1) == 1,
             ($urandom_range(7) == 0) ? int'($urandom_range(1, 10)) : -1, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
